// File: rtl/switch_pkg.sv
// Shared types and defaults for the 2:1 switch merger.
// Port identifiers, packet bundle and a saturating add helper.
package switch_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam logic [ADDR_WIDTH_DEF-1:0] ADDR_DIV_DEF = 8'h3F;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } pkt_t;

  // Add 0..3 to an 8-bit counter, clamping at 8'hFF.
  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Synchronous packet FIFO, one per merger input port.
// Pointers carry an extra wrap bit to tell full from empty.
module switch_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  pkt_t wdata_i,
  input  logic pop_i,
  output pkt_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  pkt_t        mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer state; reset drops every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are meaningless unless pointed at.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/switch_merge.sv
// 2:1 merger: round-robin recombination of the A/B streams
// into one registered stream, with misroute counting.
module switch_merge
  import switch_pkg::*;
#(
  parameter int                  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV = ADDR_DIV_DEF,
  parameter int                  FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  rdy_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rdy_b,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  src,
  input  logic                  rdy,
  output logic [7:0]            err_cnt
);

  logic full_a, full_b;
  logic empty_a, empty_b;
  pkt_t rd_a, rd_b;
  pkt_t wr_a, wr_b;
  logic push_a, push_b;
  logic pop_a, pop_b;

  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  port_e                 src_q, src_d;
  port_e                 last_q, last_d;
  logic [7:0]            err_q, err_d;

  port_e sel;
  pkt_t  sel_pkt;
  logic  cand;
  logic  free;
  logic  load;
  logic  mis_a, mis_b;

  // Ready depends on full only; held low while reset is asserted.
  assign rdy_a  = !full_a && !rst;
  assign rdy_b  = !full_b && !rst;
  assign push_a = vld_a && rdy_a;
  assign push_b = vld_b && rdy_b;

  assign wr_a = '{addr: addr_a, data: data_a};
  assign wr_b = '{addr: addr_b, data: data_b};

  switch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_a),
    .wdata_i(wr_a),
    .pop_i  (pop_a),
    .rdata_o(rd_a),
    .full_o (full_a),
    .empty_o(empty_a)
  );

  switch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_b),
    .wdata_i(wr_b),
    .pop_i  (pop_b),
    .rdata_o(rd_b),
    .full_o (full_b),
    .empty_o(empty_b)
  );

  assign cand = !empty_a || !empty_b;
  assign free = !vld_q || rdy;
  assign load = free && cand;

  // Round-robin pick: a lone candidate wins, a tie goes away from last grant.
  always_comb begin
    sel = PORT_A;
    if (!empty_a && !empty_b) begin
      sel = (last_q == PORT_B) ? PORT_A : PORT_B;
    end else if (empty_a) begin
      sel = PORT_B;
    end
  end

  assign sel_pkt = (sel == PORT_A) ? rd_a : rd_b;
  assign pop_a   = load && (sel == PORT_A);
  assign pop_b   = load && (sel == PORT_B);

  assign mis_a = push_a && (addr_a > ADDR_DIV);
  assign mis_b = push_b && (addr_b <= ADDR_DIV);

  // Output register, grant history and misroute counter next state.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    last_d = last_q;
    err_d  = sat_add8(err_q, {1'b0, mis_a} + {1'b0, mis_b});
    if (free) vld_d = cand;
    if (load) begin
      addr_d = sel_pkt.addr;
      data_d = sel_pkt.data;
      src_d  = sel;
      last_d = sel;
    end
  end

  // State registers; reset discards any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      src_q  <= PORT_A;
      last_q <= PORT_B;
      err_q  <= 8'h00;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
      src_q  <= src_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign vld     = vld_q;
  assign addr    = addr_q;
  assign data    = data_q;
  assign src     = src_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_switch_merge.sv
// Randomized and directed bench for switch_merge.
// Reference model keeps the two port queues and output slot.
module tb_switch_merge;

  logic        clk;
  logic        rst;
  logic        vld_a, vld_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        rdy_a, rdy_b;
  logic        vld;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        src;
  logic        rdy;
  logic [7:0]  err_cnt;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } mp_t;

  mp_t         qa[$];
  mp_t         qb[$];
  bit          m_vld;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  bit          m_src;
  bit          m_last;
  int          m_err;

  switch_merge dut (
    .clk    (clk),
    .rst    (rst),
    .vld_a  (vld_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .rdy_a  (rdy_a),
    .vld_b  (vld_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .rdy_b  (rdy_b),
    .vld    (vld),
    .addr   (addr),
    .data   (data),
    .src    (src),
    .rdy    (rdy),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_vld  = 0;
    m_addr = '0;
    m_data = '0;
    m_src  = 0;
    m_last = 1;
    m_err  = 0;
  endtask

  task automatic check_outputs();
    check("vld", {31'd0, vld}, {31'd0, m_vld});
    if (m_vld) begin
      check("addr", {24'd0, addr}, {24'd0, m_addr});
      check("data", {16'd0, data}, {16'd0, m_data});
      check("src", {31'd0, src}, {31'd0, m_src});
    end
    check("err_cnt", {24'd0, err_cnt}, m_err);
    check("rdy_a", {31'd0, rdy_a}, {31'd0, qa.size() < 4});
    check("rdy_b", {31'd0, rdy_b}, {31'd0, qb.size() < 4});
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic cyc(
    input bit          va,
    input logic [7:0]  aa,
    input logic [15:0] da,
    input bit          vb,
    input logic [7:0]  ab,
    input logic [15:0] db,
    input bit          r
  );
    bit  acc_a, acc_b, ld, pick;
    int  inc;
    mp_t p;
    vld_a = va; addr_a = aa; data_a = da;
    vld_b = vb; addr_b = ab; data_b = db;
    rdy = r;
    acc_a = va && (qa.size() < 4);
    acc_b = vb && (qb.size() < 4);
    inc = 0;
    if (acc_a && aa > 8'h3F) inc++;
    if (acc_b && ab <= 8'h3F) inc++;
    ld = (!m_vld || r) && (qa.size() > 0 || qb.size() > 0);
    if (!m_vld || r) m_vld = ld;
    if (ld) begin
      if (qa.size() > 0 && qb.size() > 0) pick = !m_last;
      else pick = (qa.size() == 0);
      if (pick) p = qb.pop_front();
      else p = qa.pop_front();
      m_addr = p.a;
      m_data = p.d;
      m_src  = pick;
      m_last = pick;
    end
    if (acc_a) qa.push_back('{a: aa, d: da});
    if (acc_b) qb.push_back('{a: ab, d: db});
    m_err = (m_err + inc > 255) ? 255 : m_err + inc;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit r);
    cyc(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, r);
  endtask

  // Async reset mid-cycle; returns aligned to 1 time unit after an edge.
  task automatic reset_dut();
    vld_a = 0; vld_b = 0; rdy = 0;
    #2 rst = 1;
    #1;
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    check("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
    check("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    vld_a = 0; addr_a = '0; data_a = '0;
    vld_b = 0; addr_b = '0; data_b = '0;
    rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
    check_outputs();

    // Single packet on A
    cyc(1, 8'h10, 16'hBEEF, 0, 8'h00, 16'h0000, 1);
    check("single_lat", {31'd0, vld}, 32'd0);
    idle(1);
    check("single_vld", {31'd0, vld}, 32'd1);
    check("single_addr", {24'd0, addr}, 32'h10);
    check("single_data", {16'd0, data}, 32'hBEEF);
    check("single_src", {31'd0, src}, 32'd0);
    idle(1);

    // Repeated ties alternate A, B, A, B after reset
    reset_dut();
    cyc(1, 8'h01, 16'h1111, 1, 8'h80, 16'h2222, 1);
    cyc(1, 8'h01, 16'h1111, 1, 8'h80, 16'h2222, 1);
    check("tie0", {31'd0, src}, 32'd0);
    idle(1);
    check("tie1", {31'd0, src}, 32'd1);
    check("tie1_addr", {24'd0, addr}, 32'h80);
    idle(1);
    check("tie2", {31'd0, src}, 32'd0);
    idle(1);
    check("tie3", {31'd0, src}, 32'd1);
    idle(1);
    check("tie_done", {31'd0, vld}, 32'd0);

    // Backpressure: 5 packets with rdy low
    for (int i = 0; i < 5; i++)
      cyc(1, 8'(8'h20 + i), 16'(16'h5000 + i), 0, 8'h00, 16'h0, 0);
    check("bp_rdy_a", {31'd0, rdy_a}, 32'd0);
    check("bp_head", {24'd0, addr}, 32'h20);
    for (int i = 1; i < 5; i++) begin
      idle(1);
      check("bp_order", {24'd0, addr}, 32'(8'h20 + i));
    end
    idle(1);
    check("bp_drained", {31'd0, vld}, 32'd0);

    // Stall holds the output stable
    cyc(1, 8'h05, 16'hAAAA, 0, 8'h00, 16'h0, 0);
    cyc(1, 8'h06, 16'hBBBB, 0, 8'h00, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      check("stall_addr", {24'd0, addr}, 32'h05);
      check("stall_data", {16'd0, data}, 32'hAAAA);
    end
    idle(1);
    check("stall_next", {24'd0, addr}, 32'h06);
    idle(1);
    idle(1);

    // Misroute counting and saturation
    reset_dut();
    cyc(1, 8'h40, 16'h0040, 1, 8'h3F, 16'h003F, 1);
    check("mis_two", {24'd0, err_cnt}, 32'd2);
    idle(1);
    idle(1);
    for (int i = 0; i < 300; i++)
      cyc(1, 8'h90, 16'(i), 0, 8'h00, 16'h0, 1);
    check("mis_sat", {24'd0, err_cnt}, 32'hFF);
    idle(1);
    idle(1);

    // Reset with packets buffered and one held at the output
    cyc(1, 8'h11, 16'h0011, 1, 8'hA1, 16'h00A1, 0);
    cyc(1, 8'h12, 16'h0012, 1, 8'hA2, 16'h00A2, 0);
    check("pre_rst_vld", {31'd0, vld}, 32'd1);
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("no_stale", {31'd0, vld}, 32'd0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 3) != 0, 8'($urandom), 16'($urandom),
          ($urandom % 3) != 0, 8'($urandom), 16'($urandom),
          ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
